mii_lane_checker: RTL and testbench
===================================

# mii_lane_checker

Parametrised multi-lane MII/XGMII stream checker for the MII test environment. Counts data, control, idle, start, terminate and error characters per monitoring window, and tracks frame boundaries with a per-byte frame state machine that flags protocol violations. Counters saturate and can be cleared. At the end of each window the block presents a one-cycle `stats_valid` strobe, so the bench or a register bank can capture the results without `$display`.

## Interface
- `DATA_WIDTH`, default 64: data bus width; multiple of 8, range 8..256. `LANES = DATA_WIDTH/8`.
- `CNT_WIDTH`, default 32: width of every statistics counter, range 8..64.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  level; monitoring window open while high.
- `clear`  in  1  synchronous pulse; zeroes all counters.
- `valid_in`  in  1  qualifies `ctrl_in`/`data_in` this cycle.
- `ctrl_in`  in  LANES  per-byte control flag; bit i covers `data_in[8i+7:8i]`.
- `data_in`  in  DATA_WIDTH  character bus; lane 0 is the earliest byte.
- `data_count`, `ctrl_count`, `idle_count`, `start_count`, `term_count`, `err_count`, `viol_count`  out  CNT_WIDTH each  statistics counters.
- `frame_count`  out  CNT_WIDTH  number of completed frames (start followed by terminate).
- `in_frame`  out  1  frame FSM state after the last processed lane.
- `monitoring`  out  1  high in the MONITORING state.
- `stats_valid`  out  1  one-cycle strobe when a window closes.

## Operation
- Top FSM has three states: WAITING, MONITORING, REPORT.
  - WAITING -> MONITORING when `enable`=1.
  - MONITORING -> REPORT when `enable`=0.
  - REPORT -> WAITING unconditionally.
- `stats_valid`=1 only in REPORT. Counters are frozen in WAITING and REPORT.
- On WAITING -> MONITORING the frame FSM is forced to IDLE. Counters are not cleared.
- A word is processed only when the state is MONITORING and `valid_in`=1. Lanes are processed in order 0..LANES-1, and the frame state chains between lanes within the cycle.
- Classification per lane:
  - `ctrl`=0: data. In-frame: fine. Out of frame: violation.
  - `ctrl`=1: `ctrl_count`++, then decode the byte:
    - 0x07 Idle: `idle_count`++. Out of frame: fine. In-frame: violation, frame FSM -> IDLE (truncated frame, not counted).
    - 0xFB Start: `start_count`++. Out of frame: -> IN_FRAME. In-frame: violation, stays IN_FRAME.
    - 0xFD Terminate: `term_count`++. In-frame: -> IDLE and `frame_count`++. Out of frame: violation.
    - 0xFE Error: `err_count`++. No state change, not a violation.
    - Any other code: violation, no state change.
- Each counter adds its per-word sum (0..LANES) in one cycle. Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- `clear` zeroes all counters. It does not change the top FSM or the frame FSM. If `clear` and a counted word arrive in the same cycle, `clear` wins and that word is discarded from the counts; the frame FSM still advances on it.
- Reset values: all counters 0, `in_frame`=0, `monitoring`=0, `stats_valid`=0, top FSM WAITING, frame FSM IDLE.
- Reset asserted mid-window returns every output to its reset value immediately.

## Timing
- All outputs are registered.
- The `enable` rise sampled at edge E puts the block in MONITORING after E. The first word counted is the one sampled at edge E+1.
- A word sampled at edge N is reflected in the counters and `in_frame` after edge N.
- The `enable` fall sampled at edge F puts the block in REPORT after F. The word sampled at F is still counted, and `stats_valid` is high for the cycle after F.
- `enable` re-asserted during REPORT is honoured on the following edge: REPORT -> WAITING -> MONITORING, so there is a 2-cycle gap.

## Test plan
- **Clean frame** (DATA_WIDTH=64): word0 ctrl=0x01, lane0=0xFB, lanes 1-7 data; word1 ctrl=0x00; word2 ctrl=0xFE, lane0 data, lanes 1-7 0xFD then 0x07×6; then `enable` fall. Required: `start_count`=1, `term_count`=1, `frame_count`=1, `idle_count`=6, `data_count`=16, `ctrl_count`=8, `viol_count`=0, and `stats_valid` high exactly one cycle.
- **Violations**: data byte outside a frame, a 0xFD outside a frame, 0xFB twice within a frame, 0x07 within a frame, and code 0x55. Required: `viol_count`=5, `frame_count`=0, `in_frame`=0 at the end.
- **Error characters**: 3×0xFE inside a frame. Required: `err_count`=3, `viol_count`=0, `in_frame` unchanged.
- **Saturation** (CNT_WIDTH=8): 40 all-data words in-frame. Required: `data_count`=255 and it holds there.
- **clear collision**: `clear` asserted in the same cycle as a word with a start in lane 0. Required: all counters 0 and `in_frame`=1 afterwards. `valid_in`=0 words are not counted.
- **Mid-window reset**: `rst_n` dropped during a frame. Required: all outputs 0 asynchronously; after release the block is in WAITING.

Source files
------------

// File: rtl/mii_lane_checker.sv
// Multi-lane MII/XGMII character checker: per-window statistics counters plus a
// per-byte frame state machine that flags protocol violations.
module mii_lane_checker #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    clear,
    input  logic                    valid_in,
    input  logic [DATA_WIDTH/8-1:0] ctrl_in,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [CNT_WIDTH-1:0]    data_count,
    output logic [CNT_WIDTH-1:0]    ctrl_count,
    output logic [CNT_WIDTH-1:0]    idle_count,
    output logic [CNT_WIDTH-1:0]    start_count,
    output logic [CNT_WIDTH-1:0]    term_count,
    output logic [CNT_WIDTH-1:0]    err_count,
    output logic [CNT_WIDTH-1:0]    viol_count,
    output logic [CNT_WIDTH-1:0]    frame_count,
    output logic                    in_frame,
    output logic                    monitoring,
    output logic                    stats_valid
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int SUM_W = $clog2(LANES + 1);
    localparam int NCNT  = 8;

    localparam int C_DATA  = 0;
    localparam int C_CTRL  = 1;
    localparam int C_IDLE  = 2;
    localparam int C_START = 3;
    localparam int C_TERM  = 4;
    localparam int C_ERR   = 5;
    localparam int C_VIOL  = 6;
    localparam int C_FRAME = 7;

    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_ERR   = 8'hFE;

    typedef enum logic [1:0] {
        WAITING    = 2'd0,
        MONITORING = 2'd1,
        REPORT     = 2'd2
    } top_state_e;

    typedef enum logic {
        FR_IDLE     = 1'b0,
        FR_IN_FRAME = 1'b1
    } frame_state_e;

    top_state_e           state_q, state_d;
    frame_state_e         frame_q, frame_d;
    frame_state_e         frame_word;
    logic [CNT_WIDTH-1:0] cnt_q [NCNT];
    logic [CNT_WIDTH-1:0] cnt_d [NCNT];
    logic [SUM_W-1:0]     sum   [NCNT];
    logic                 process_word;
    logic [7:0]           lane_byte;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [SUM_W-1:0]     b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {{(CNT_WIDTH + 1 - SUM_W){1'b0}}, b};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    assign process_word = (state_q == MONITORING) && valid_in;

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAITING:    if (enable)  state_d = MONITORING;
            MONITORING: if (!enable) state_d = REPORT;
            REPORT:     state_d = WAITING;
            default:    state_d = WAITING;
        endcase
    end

    // Lanes are walked in order so the frame state chains through the word.
    always_comb begin
        frame_word = frame_q;
        lane_byte  = '0;
        for (int unsigned k = 0; k < NCNT; k++) sum[k] = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_byte = data_in[8*i +: 8];
            if (!ctrl_in[i]) begin
                sum[C_DATA] = sum[C_DATA] + SUM_W'(1);
                if (frame_word == FR_IDLE) sum[C_VIOL] = sum[C_VIOL] + SUM_W'(1);
            end else begin
                sum[C_CTRL] = sum[C_CTRL] + SUM_W'(1);
                case (lane_byte)
                    CH_IDLE: begin
                        sum[C_IDLE] = sum[C_IDLE] + SUM_W'(1);
                        if (frame_word == FR_IN_FRAME) begin
                            sum[C_VIOL] = sum[C_VIOL] + SUM_W'(1);
                            frame_word  = FR_IDLE;
                        end
                    end
                    CH_START: begin
                        sum[C_START] = sum[C_START] + SUM_W'(1);
                        if (frame_word == FR_IN_FRAME) sum[C_VIOL] = sum[C_VIOL] + SUM_W'(1);
                        else                           frame_word  = FR_IN_FRAME;
                    end
                    CH_TERM: begin
                        sum[C_TERM] = sum[C_TERM] + SUM_W'(1);
                        if (frame_word == FR_IN_FRAME) begin
                            frame_word   = FR_IDLE;
                            sum[C_FRAME] = sum[C_FRAME] + SUM_W'(1);
                        end else begin
                            sum[C_VIOL] = sum[C_VIOL] + SUM_W'(1);
                        end
                    end
                    CH_ERR:  sum[C_ERR]  = sum[C_ERR] + SUM_W'(1);
                    default: sum[C_VIOL] = sum[C_VIOL] + SUM_W'(1);
                endcase
            end
        end
    end

    always_comb begin
        frame_d = frame_q;
        if ((state_q == WAITING) && enable) frame_d = FR_IDLE;
        else if (process_word)              frame_d = frame_word;
    end

    // Clear takes priority over the word's contribution but not over its frame tracking.
    always_comb begin
        for (int unsigned k = 0; k < NCNT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clear)             cnt_d[k] = '0;
            else if (process_word) cnt_d[k] = sat_add(cnt_q[k], sum[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAITING;
            frame_q <= FR_IDLE;
            for (int unsigned k = 0; k < NCNT; k++) cnt_q[k] <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            for (int unsigned k = 0; k < NCNT; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign data_count  = cnt_q[C_DATA];
    assign ctrl_count  = cnt_q[C_CTRL];
    assign idle_count  = cnt_q[C_IDLE];
    assign start_count = cnt_q[C_START];
    assign term_count  = cnt_q[C_TERM];
    assign err_count   = cnt_q[C_ERR];
    assign viol_count  = cnt_q[C_VIOL];
    assign frame_count = cnt_q[C_FRAME];
    assign in_frame    = (frame_q == FR_IN_FRAME);
    assign monitoring  = (state_q == MONITORING);
    assign stats_valid = (state_q == REPORT);

endmodule

// File: tb/tb_mii_lane_checker.sv
// Scoreboard bench for mii_lane_checker: a behavioural model queues the expected
// outputs per cycle; scenario tasks add fixed expectations from hand-worked sequences.
module tb_mii_lane_checker;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int LN = DW / 8;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          enable   = 1'b0;
    logic          clear    = 1'b0;
    logic          valid_in = 1'b0;
    logic [LN-1:0] ctrl_in  = '0;
    logic [DW-1:0] data_in  = '0;
    logic [CW-1:0] data_count, ctrl_count, idle_count, start_count;
    logic [CW-1:0] term_count, err_count, viol_count, frame_count;
    logic          in_frame, monitoring, stats_valid;

    mii_lane_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .valid_in(valid_in),
        .ctrl_in(ctrl_in), .data_in(data_in),
        .data_count(data_count), .ctrl_count(ctrl_count), .idle_count(idle_count),
        .start_count(start_count), .term_count(term_count), .err_count(err_count),
        .viol_count(viol_count), .frame_count(frame_count),
        .in_frame(in_frame), .monitoring(monitoring), .stats_valid(stats_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][CW-1:0] cnt;
        logic               in_frame;
        logic               mon;
        logic               sv;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    int            n_vec  = 0;
    int            n_fail = 0;
    int            m_cnt[8];
    bit            m_in_frame;
    int            m_state;
    logic [CW-1:0] dut_cnt[8];

    assign dut_cnt[0] = data_count;
    assign dut_cnt[1] = ctrl_count;
    assign dut_cnt[2] = idle_count;
    assign dut_cnt[3] = start_count;
    assign dut_cnt[4] = term_count;
    assign dut_cnt[5] = err_count;
    assign dut_cnt[6] = viol_count;
    assign dut_cnt[7] = frame_count;

    function automatic string cname(input int i);
        case (i)
            0: return "data_count";
            1: return "ctrl_count";
            2: return "idle_count";
            3: return "start_count";
            4: return "term_count";
            5: return "err_count";
            6: return "viol_count";
            default: return "frame_count";
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_cnt[k] = 0;
        m_in_frame = 1'b0;
        m_state    = 0;
    endtask

    // Drive one cycle of stimulus, queue the model's view of the outputs after the edge.
    task automatic tick(input logic v, input logic en, input logic clr,
                        input logic [LN-1:0] c, input logic [DW-1:0] d);
        exp_t       e;
        int         add[8];
        bit         proc;
        bit         f;
        logic [7:0] b;
        valid_in = v; enable = en; clear = clr; ctrl_in = c; data_in = d;
        proc = (m_state == 1) && v;
        f    = m_in_frame;
        for (int k = 0; k < 8; k++) add[k] = 0;
        if (proc) begin
            for (int l = 0; l < LN; l++) begin
                b = d[8*l +: 8];
                if (!c[l]) begin
                    add[0]++;
                    if (!f) add[6]++;
                end else begin
                    add[1]++;
                    if (b == 8'h07) begin
                        add[2]++;
                        if (f) begin add[6]++; f = 1'b0; end
                    end else if (b == 8'hFB) begin
                        add[3]++;
                        if (f) add[6]++; else f = 1'b1;
                    end else if (b == 8'hFD) begin
                        add[4]++;
                        if (f) begin f = 1'b0; add[7]++; end else add[6]++;
                    end else if (b == 8'hFE) begin
                        add[5]++;
                    end else begin
                        add[6]++;
                    end
                end
            end
        end
        if (m_state == 0 && en) m_in_frame = 1'b0;
        else if (proc)          m_in_frame = f;
        for (int k = 0; k < 8; k++) begin
            if (clr)       m_cnt[k] = 0;
            else if (proc) m_cnt[k] = (m_cnt[k] + add[k] > 255) ? 255 : m_cnt[k] + add[k];
        end
        case (m_state)
            0:       if (en)  m_state = 1;
            1:       if (!en) m_state = 2;
            default: m_state = 0;
        endcase
        for (int k = 0; k < 8; k++) e.cnt[k] = CW'(m_cnt[k]);
        e.in_frame = m_in_frame;
        e.mon      = (m_state == 1);
        e.sv       = (m_state == 2);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            for (int k = 0; k < 8; k++) begin
                n_vec++;
                if (dut_cnt[k] !== mon_e.cnt[k]) begin
                    n_fail++;
                    $display("FAIL sb.%s t=%0t: got %0d expected %0d", cname(k), $time, dut_cnt[k], mon_e.cnt[k]);
                end
            end
            n_vec++;
            if (in_frame !== mon_e.in_frame) begin
                n_fail++;
                $display("FAIL sb.in_frame t=%0t: got %b expected %b", $time, in_frame, mon_e.in_frame);
            end
            n_vec++;
            if (monitoring !== mon_e.mon) begin
                n_fail++;
                $display("FAIL sb.monitoring t=%0t: got %b expected %b", $time, monitoring, mon_e.mon);
            end
            n_vec++;
            if (stats_valid !== mon_e.sv) begin
                n_fail++;
                $display("FAIL sb.stats_valid t=%0t: got %b expected %b", $time, stats_valid, mon_e.sv);
            end
        end
    end

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (dut_cnt[k] !== '0) begin
                n_fail++;
                $display("FAIL reset.%s: got %0d expected 0", cname(k), dut_cnt[k]);
            end
        end
        n_vec++;
        if ({in_frame, monitoring, stats_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset.flags: got %b expected 000", {in_frame, monitoring, stats_valid});
        end
        #4 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_clean_frame();
        int sv_seen = 0;
        tick(1'b0, 1'b1, 1'b0, 8'h00, '0);
        tick(1'b1, 1'b1, 1'b0, 8'h01, 64'h11223344556677FB);
        tick(1'b1, 1'b1, 1'b0, 8'h00, 64'h0102030405060708);
        tick(1'b1, 1'b0, 1'b0, 8'hFE, 64'h070707070707FDAA);
        sv_seen += int'(stats_valid);
        n_vec++;
        if ({start_count, term_count, frame_count} !== {8'd1, 8'd1, 8'd1}) begin
            n_fail++;
            $display("FAIL clean.start_term_frame: got %0d/%0d/%0d expected 1/1/1", start_count, term_count, frame_count);
        end
        n_vec++;
        if ({idle_count, data_count, ctrl_count, viol_count} !== {8'd6, 8'd16, 8'd8, 8'd0}) begin
            n_fail++;
            $display("FAIL clean.idle_data_ctrl_viol: got %0d/%0d/%0d/%0d expected 6/16/8/0",
                     idle_count, data_count, ctrl_count, viol_count);
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00, '0);
        sv_seen += int'(stats_valid);
        tick(1'b0, 1'b0, 1'b0, 8'h00, '0);
        sv_seen += int'(stats_valid);
        n_vec++;
        if (sv_seen != 1) begin
            n_fail++;
            $display("FAIL clean.stats_valid_cycles: got %0d expected 1", sv_seen);
        end
    endtask

    task automatic test_violations();
        tick(1'b0, 1'b0, 1'b1, 8'h00, '0);
        tick(1'b0, 1'b1, 1'b0, 8'h00, '0);
        tick(1'b1, 1'b1, 1'b0, 8'hFE, 64'h07075507FBFBFDAA);
        tick(1'b1, 1'b0, 1'b0, 8'hFF, 64'h0707070707070707);
        tick(1'b0, 1'b0, 1'b0, 8'h00, '0);
        n_vec++;
        if ({viol_count, frame_count} !== {8'd5, 8'd0}) begin
            n_fail++;
            $display("FAIL viol.viol_frame: got %0d/%0d expected 5/0", viol_count, frame_count);
        end
        n_vec++;
        if (in_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL viol.in_frame: got %b expected 0", in_frame);
        end
    endtask

    task automatic test_error_chars();
        tick(1'b0, 1'b0, 1'b1, 8'h00, '0);
        tick(1'b0, 1'b1, 1'b0, 8'h00, '0);
        tick(1'b1, 1'b1, 1'b0, 8'h0F, 64'h44332211FEFEFEFB);
        n_vec++;
        if ({err_count, viol_count, 7'd0, in_frame} !== {8'd3, 8'd0, 8'd1}) begin
            n_fail++;
            $display("FAIL err.err_viol_inframe: got %0d/%0d/%b expected 3/0/1", err_count, viol_count, in_frame);
        end
        tick(1'b1, 1'b0, 1'b0, 8'h00, 64'h0F0E0D0C0B0A0908);
        n_vec++;
        if (in_frame !== 1'b1 || err_count !== 8'd3) begin
            n_fail++;
            $display("FAIL err.hold: got in_frame=%b err=%0d expected 1/3", in_frame, err_count);
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00, '0);
    endtask

    task automatic test_saturation();
        tick(1'b0, 1'b0, 1'b1, 8'h00, '0);
        tick(1'b0, 1'b1, 1'b0, 8'h00, '0);
        tick(1'b1, 1'b1, 1'b0, 8'h01, 64'hA5A5A5A5A5A5A5FB);
        repeat (40) tick(1'b1, 1'b1, 1'b0, 8'h00, 64'hA5A5A5A5A5A5A5A5);
        n_vec++;
        if ({data_count, ctrl_count, viol_count} !== {8'd255, 8'd1, 8'd0}) begin
            n_fail++;
            $display("FAIL sat.data_ctrl_viol: got %0d/%0d/%0d expected 255/1/0", data_count, ctrl_count, viol_count);
        end
        tick(1'b1, 1'b0, 1'b0, 8'h00, 64'h5A5A5A5A5A5A5A5A);
        n_vec++;
        if (data_count !== 8'd255) begin
            n_fail++;
            $display("FAIL sat.hold: got %0d expected 255", data_count);
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00, '0);
    endtask

    task automatic test_clear_collision();
        tick(1'b0, 1'b1, 1'b0, 8'h00, '0);
        tick(1'b1, 1'b1, 1'b1, 8'h01, 64'h11111111111111FB);
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (dut_cnt[k] !== '0) begin
                n_fail++;
                $display("FAIL clear.%s: got %0d expected 0", cname(k), dut_cnt[k]);
            end
        end
        n_vec++;
        if (in_frame !== 1'b1) begin
            n_fail++;
            $display("FAIL clear.in_frame: got %b expected 1", in_frame);
        end
        tick(1'b0, 1'b1, 1'b0, 8'hFF, 64'h5555555555555555);
        n_vec++;
        if ({ctrl_count, viol_count} !== 16'd0) begin
            n_fail++;
            $display("FAIL clear.invalid_word: got ctrl=%0d viol=%0d expected 0/0", ctrl_count, viol_count);
        end
        tick(1'b1, 1'b1, 1'b0, 8'h80, 64'hFD22222222222222);
        n_vec++;
        if ({data_count, frame_count, in_frame} !== {8'd7, 8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL clear.resume: got data=%0d frame=%0d in_frame=%b expected 7/1/0",
                     data_count, frame_count, in_frame);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b0, 1'b0, 1'b0, 8'h00, '0);
        n_vec++;
        if ({monitoring, stats_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b.report: got mon/sv=%b expected 01", {monitoring, stats_valid});
        end
        tick(1'b1, 1'b1, 1'b0, 8'h00, 64'h3333333333333333);
        n_vec++;
        if ({monitoring, stats_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b.waiting: got mon/sv=%b expected 00", {monitoring, stats_valid});
        end
        tick(1'b1, 1'b1, 1'b0, 8'h00, 64'h4444444444444444);
        n_vec++;
        if ({monitoring, data_count} !== {1'b1, 8'd7}) begin
            n_fail++;
            $display("FAIL b2b.reopen: got mon=%b data=%0d expected 1/7", monitoring, data_count);
        end
        tick(1'b1, 1'b1, 1'b0, 8'h00, 64'h6666666666666666);
        n_vec++;
        if ({data_count, viol_count} !== {8'd15, 8'd8}) begin
            n_fail++;
            $display("FAIL b2b.counted: got data=%0d viol=%0d expected 15/8", data_count, viol_count);
        end
    endtask

    task automatic test_mid_reset();
        tick(1'b1, 1'b1, 1'b0, 8'h01, 64'h77777777777777FB);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (dut_cnt[k] !== '0) begin
                n_fail++;
                $display("FAIL midrst.%s: got %0d expected 0", cname(k), dut_cnt[k]);
            end
        end
        n_vec++;
        if ({in_frame, monitoring, stats_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst.flags: got %b expected 000", {in_frame, monitoring, stats_valid});
        end
        model_reset();
        #2 rst_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 8'h00, 64'h8888888888888888);
        n_vec++;
        if ({monitoring, data_count} !== {1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL midrst.waiting: got mon=%b data=%0d expected 0/0", monitoring, data_count);
        end
        tick(1'b0, 1'b1, 1'b0, 8'h00, '0);
        n_vec++;
        if (monitoring !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst.reopen: got %b expected 1", monitoring);
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_clean_frame();
        test_violations();
        test_error_chars();
        test_saturation();
        test_clear_collision();
        test_back_to_back();
        test_mid_reset();
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
